// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the TDM serial link (demux side and serializer side).
// Holds the FSM state encoding, default frame geometry and the even-parity
// helper used on both ends of the link.
package tdm_demux4_pkg;

    // IDLE hunts for start-of-frame, COLLECT gathers the remaining slots.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } tdm_state_e;

    localparam int TDM_DEF_NUM_CH = 4;
    localparam int TDM_DEF_DATA_W = 8;
    localparam int TDM_DEF_CNT_W  = 2;

    // Returns 1 when the supplied bits do not have even parity. Callers
    // zero-extend narrower vectors, which leaves the parity unchanged.
    function automatic logic tdm_even_par_bad(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/tdm_demux4_slot_cnt.sv
// Slot counter for the TDM demux: clear, load-to-1 (slot 0 just captured)
// and increment, with a flag marking the final slot of the frame.
// Priority when several controls are raised together: clear, load, increment.
module tdm_slot_cnt #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CNT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the TDM serial link. Collects NUM_CH slots starting at a
// start-of-frame marker and publishes them atomically on out_data with a
// one-cycle out_valid pulse. A start-of-frame seen mid-frame pulses frame_err
// and resynchronises onto the new frame.
//
// Optional build macro: TDM_DEMUX_PARITY_EN adds in_par / par_err and even
// parity checking over {in_par, in_data}; a frame containing a parity error
// is dropped and reported on par_err instead of out_valid.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | hunting for sof; non-sof samples are dropped silently
// ST_COLLECT  | slot 0 captured, gathering slots 1..NUM_CH-1
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int NUM_CH = TDM_DEF_NUM_CH,
    parameter int DATA_W = TDM_DEF_DATA_W,
    parameter int CNT_W  = TDM_DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_W-1:0]        in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                     in_par,
    output logic                     par_err,
`endif
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     frame_err,
    output logic                     busy
);

    tdm_state_e               state_q, state_d;
    logic [DATA_W-1:0]        shadow_q [NUM_CH-1];
    logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     frame_err_q, frame_err_d;

    logic                     cnt_clr, cnt_load1, cnt_inc;
    logic [CNT_W-1:0]         cnt;
    logic                     cnt_last;

    logic                     sh_we;
    logic [CNT_W-1:0]         sh_idx;
    logic                     out_load;

`ifdef TDM_DEMUX_PARITY_EN
    logic                     par_flag_q, par_flag_d;
    logic                     par_err_q, par_err_d;
    logic                     samp_bad;
`endif

    tdm_slot_cnt #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_slot_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    // Next-state and control decode for the frame FSM.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_load1   = 1'b0;
        cnt_inc     = 1'b0;
        sh_we       = 1'b0;
        sh_idx      = cnt;
        out_load    = 1'b0;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_flag_d  = par_flag_q;
        par_err_d   = 1'b0;
        samp_bad    = tdm_even_par_bad(64'({in_par, in_data}));
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    sh_we     = 1'b1;
                    sh_idx    = '0;
                    cnt_load1 = 1'b1;
                    state_d   = ST_COLLECT;
`ifdef TDM_DEMUX_PARITY_EN
                    par_flag_d = samp_bad;
`endif
                end
            end
            ST_COLLECT: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Resync: drop the partial frame, new frame starts here.
                        frame_err_d = 1'b1;
                        sh_we       = 1'b1;
                        sh_idx      = '0;
                        cnt_load1   = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        par_flag_d  = samp_bad;
`endif
                    end else if (!cnt_last) begin
                        sh_we   = 1'b1;
                        cnt_inc = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                        par_flag_d = par_flag_q | samp_bad;
`endif
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = ST_IDLE;
`ifdef TDM_DEMUX_PARITY_EN
                        par_flag_d = 1'b0;
                        if (par_flag_q || samp_bad) begin
                            par_err_d = 1'b1;
                        end else begin
                            out_load    = 1'b1;
                            out_valid_d = 1'b1;
                        end
`else
                        out_load    = 1'b1;
                        out_valid_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Assemble the published frame: shadowed slots in the low lanes, the
    // slot being presented now in the top lane.
    always_comb begin
        out_data_d = out_data_q;
        if (out_load) begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                out_data_d[k*DATA_W +: DATA_W] = shadow_q[k];
            end
            out_data_d[(NUM_CH-1)*DATA_W +: DATA_W] = in_data;
        end
    end

    // FSM, output and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Shadow registers holding slots 0..NUM_CH-2 of the frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH - 1; k++) begin
                if (sh_we && (sh_idx == CNT_W'(k))) begin
                    shadow_q[k] <= in_data;
                end
            end
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    // Frame-local sticky parity flag and the parity error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_flag_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            par_flag_q <= par_flag_d;
            par_err_q  <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4 (NUM_CH=4, DATA_W=8): directed vector table,
// reset-mid-frame sequence, optional parity sequence, then randomized
// traffic compared against a queue-based frame model.
module tb_tdm_demux4;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof   = 1'b0;
    logic [7:0]  in_data  = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        frame_err;
    logic        busy;
`ifdef TDM_DEMUX_PARITY_EN
    logic        in_par   = 1'b0;
    logic        par_err;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic        ev;
        logic        ee;
        logic        eb;
        logic [31:0] eod;
    } vec_t;

    vec_t tbl[$];

    tdm_demux4 #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
`ifdef TDM_DEMUX_PARITY_EN
        .in_par    (in_par),
        .par_err   (par_err),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Present one input cycle, then sample just after the capturing edge.
    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic bad_par);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
        in_par   = (^d) ^ bad_par;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t t, input string nm);
        drive(t.v, t.s, t.d, 1'b0);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(t.ev));
        chk({nm, ".frame_err"}, 32'(frame_err), 32'(t.ee));
        chk({nm, ".busy"},      32'(busy),      32'(t.eb));
        chk({nm, ".out_data"},  out_data,       t.eod);
`ifdef TDM_DEMUX_PARITY_EN
        chk({nm, ".par_err"},   32'(par_err),   32'd0);
`endif
    endtask

    function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                                input logic ev, input logic ee, input logic eb,
                                input logic [31:0] eod);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.ev = ev; t.ee = ee; t.eb = eb; t.eod = eod;
        return t;
    endfunction

    // Reference model state: frame in progress as a queue of samples.
    bit          m_in;
    logic [7:0]  m_q[$];
    logic [31:0] m_od;

    initial begin
        // Reset state
        #12;
        chk("reset.out_data",  out_data,         32'h0);
        chk("reset.out_valid", 32'(out_valid),   32'h0);
        chk("reset.frame_err", 32'(frame_err),   32'h0);
        chk("reset.busy",      32'(busy),        32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frame
        tbl.push_back(mk(1, 1, 8'h11, 0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 8'h22, 0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 8'h33, 0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 8'h44, 1, 0, 0, 32'h44332211));
        // Stall between slots 1 and 2
        tbl.push_back(mk(1, 1, 8'h11, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h22, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(0, 0, 8'hF0, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(0, 1, 8'hF1, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(0, 0, 8'hF2, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h33, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h44, 1, 0, 0, 32'h44332211));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h44332211));
        // Mid-frame sof
        tbl.push_back(mk(1, 1, 8'hAA, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'hBB, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 1, 8'h01, 0, 1, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h03, 0, 0, 1, 32'h44332211));
        tbl.push_back(mk(1, 0, 8'h04, 1, 0, 0, 32'h04030201));
        // Sync hunt, then back-to-back frames
        tbl.push_back(mk(1, 0, 8'h55, 0, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h66, 0, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 1, 8'h01, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h02, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h03, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h04, 1, 0, 0, 32'h04030201));
        tbl.push_back(mk(1, 1, 8'h05, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h06, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h07, 0, 0, 1, 32'h04030201));
        tbl.push_back(mk(1, 0, 8'h08, 1, 0, 0, 32'h08070605));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 32'h08070605));

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset mid-frame: partial frame discarded, outputs forced to 0.
        drive(1, 1, 8'h12, 0);
        drive(1, 0, 8'h34, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("rstmid.out_data",  out_data,       32'h0);
        chk("rstmid.busy",      32'(busy),      32'h0);
        chk("rstmid.out_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 1, 8'hDE, 0, 0, 1, 32'h0), "rstfr0");
        apply(mk(1, 0, 8'hAD, 0, 0, 1, 32'h0), "rstfr1");
        apply(mk(1, 0, 8'hBE, 0, 0, 1, 32'h0), "rstfr2");
        apply(mk(1, 0, 8'hEF, 1, 0, 0, 32'hEFBEADDE), "rstfr3");

`ifdef TDM_DEMUX_PARITY_EN
        // Wrong parity on slot 2: frame dropped, par_err pulses instead.
        drive(1, 1, 8'h01, 0);
        drive(1, 0, 8'h02, 0);
        drive(1, 0, 8'h03, 1);
        drive(1, 0, 8'h04, 0);
        chk("par.par_err",   32'(par_err),   32'h1);
        chk("par.out_valid", 32'(out_valid), 32'h0);
        chk("par.out_data",  out_data,       32'hEFBEADDE);
        drive(0, 0, 8'h00, 0);
        chk("par.par_err_pulse", 32'(par_err), 32'h0);
`endif

        // Randomized traffic against the frame model.
        m_in = 1'b0;
        m_q.delete();
        m_od = 32'hEFBEADDE;
        drive(0, 0, 8'h00, 0);
        for (int n = 0; n < 3000; n++) begin
            logic       v, s, ev, ee;
            logic [7:0] d;
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 5) == 0);
            d  = 8'($urandom);
            ev = 1'b0;
            ee = 1'b0;
            if (v) begin
                if (s) begin
                    ee = m_in;
                    m_q.delete();
                    m_q.push_back(d);
                    m_in = 1'b1;
                end else if (m_in) begin
                    m_q.push_back(d);
                    if (m_q.size() == NUM_CH) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            m_od[k*8 +: 8] = m_q[k];
                        end
                        ev   = 1'b1;
                        m_in = 1'b0;
                        m_q.delete();
                    end
                end
            end
            apply(mk(v, s, d, ev, ee, m_in, m_od), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receiving end of the team's time-division multiplexed serial link.
- Accepts one sample per valid cycle, with a start-of-frame marker on slot 0.
- Collects NUM_CH consecutive samples and then publishes them together as parallel channel outputs, with a one-cycle valid pulse.
- Sits downstream of the mux-based serializer and feeds the per-channel consumers.

Parameters:
- NUM_CH, 4: channels (slots) per frame; legal range 2..16.
- DATA_W, 8: bits per sample.
- CNT_W, 2: slot counter width; must be at least clog2(NUM_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sof are meaningful this cycle.
- in_sof  input  1  marks slot 0 of a frame; qualified by in_valid.
- in_data  input  DATA_W  current slot sample.
- out_data  output  NUM_CH*DATA_W  assembled frame; slot k occupies bits [k*DATA_W +: DATA_W], so slot 0 is the LSBs.
- out_valid  output  1  one-cycle pulse when out_data has been updated.
- frame_err  output  1  one-cycle pulse when in_sof arrives mid-frame.
- busy  output  1  high while in COLLECT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slot counter=0, shadow regs=0.
  - out_data=0, out_valid=0, frame_err=0, busy=0.
  - Reset asserted mid-frame discards the partial frame. out_data returns to 0.
- FSM states: IDLE (hunting for sof), COLLECT.
- IDLE:
  - in_valid & in_sof: shadow[0]<=in_data, cnt<=1, go to COLLECT.
  - in_valid & !in_sof: sample dropped silently, no error (sync hunt).
  - !in_valid: hold.
- COLLECT:
  - !in_valid: stall. All state held; no timeout.
  - in_valid & !in_sof & cnt<NUM_CH-1: shadow[cnt]<=in_data, cnt<=cnt+1.
  - in_valid & !in_sof & cnt==NUM_CH-1:
    - out_data<={in_data, shadow[NUM_CH-2..0]}, loaded atomically.
    - out_valid<=1 for exactly one cycle; cnt<=0; go to IDLE.
  - in_valid & in_sof (any cnt):
    - frame_err<=1 for one cycle; the partial frame is discarded.
    - shadow[0]<=in_data, cnt<=1, stay in COLLECT (resync on the new frame).
- Latency: out_valid and the new out_data appear on the clock edge that captures the last slot, i.e. visible the cycle after the last slot is presented.
- out_data holds its value between completed frames. It never exposes a partial frame.
- Back-to-back frames: in_sof in the cycle immediately after the last slot is accepted in IDLE. Sustained throughput is one frame per NUM_CH valid cycles.
- out_valid and frame_err are never both high in the same cycle.
- busy equals (state==COLLECT), registered.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- Defined:
  - Adds input in_par (1 bit) and output par_err (1 bit, reset 0). Even parity is checked over {in_par, in_data} on every accepted sample, including slot 0.
  - Any mismatch sets a frame-local sticky flag, cleared on sof or on completion.
  - On completion with the flag set: out_data is not updated, out_valid stays 0, and par_err pulses for one cycle instead.
  - A frame discarded by frame_err does not raise par_err.
- Undefined: in_par and par_err do not exist; no parity checking.

Decomposition:
- Shared include tdm_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_COLLECT=1'b1;
  - default NUM_CH/DATA_W;
  - the even-parity function, which the serializer side also uses.
- Sub-module tdm_slot_cnt: counter with clear, load-to-1 and increment, plus a last-slot flag (cnt==NUM_CH-1).
- The FSM, shadow regs and output regs stay in tdm_demux4.

Test Plan (NUM_CH=4, DATA_W=8):
- Clean frame: sof+0x11, then 0x22, 0x33, 0x44 on consecutive valid cycles -> next cycle out_data=0x44332211, out_valid high 1 cycle, frame_err=0.
- Stall: the same frame with in_valid low for 3 cycles between slots 1 and 2 -> identical out_data=0x44332211; busy stays 1 throughout the gap.
- Mid-frame sof: sof+0xAA, 0xBB, then sof+0x01, 0x02, 0x03, 0x04 -> frame_err pulse at the second sof; out_data=0x04030201; out_data unchanged before that.
- Sync hunt plus back-to-back: 0x55, 0x66 without sof (dropped), then two consecutive frames 0x01..0x04 and 0x05..0x08 -> two out_valid pulses 4 cycles apart, giving 0x04030201 then 0x08070605.
- Reset mid-frame: rst_n low after 2 slots -> all outputs 0 immediately; after release, a full frame 0xDE,0xAD,0xBE,0xEF -> out_data=0xEFBEADDE.
- Parity (TDM_DEMUX_PARITY_EN): slot 2 sent with a wrong in_par -> par_err pulses 1 cycle, out_valid stays 0, out_data keeps its previous frame.
